// File: rtl/anchor_feature_collector.sv
// Packs octree feature beats into full anchor features, double-buffers them in
// ping-pong slots for the renderer, and closes each search pass with a count.
module anchor_feature_collector #(
  parameter int DATA_BUS_WIDTH   = 64,
  parameter int FEATURE_LENTH    = 9,
  parameter int ANCHOR_CNT_WIDTH = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [DATA_BUS_WIDTH-1:0]               beat_in,
  input  logic                                    beat_avail,
  output logic                                    beat_accept,
  input  logic                                    search_done,
  output logic [FEATURE_LENTH*DATA_BUS_WIDTH-1:0] anc_feature,
  output logic [ANCHOR_CNT_WIDTH-1:0]             anc_index,
  output logic                                    anc_valid,
  input  logic                                    anc_ready,
  output logic                                    pass_done,
  output logic [ANCHOR_CNT_WIDTH-1:0]             pass_count,
  output logic                                    frag_err,
  input  logic                                    err_clr
);

  localparam int AW = FEATURE_LENTH * DATA_BUS_WIDTH;
  localparam int CW = (FEATURE_LENTH > 1) ? $clog2(FEATURE_LENTH) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(FEATURE_LENTH - 1);

  typedef enum logic {COLLECT, FLUSH} state_t;

  state_t                      state;
  logic [1:0]                  full;
  logic                        wr_slot;
  logic                        rd_slot;
  logic [CW-1:0]               beat_cnt;
  logic [ANCHOR_CNT_WIDTH-1:0] anc_cnt;
  logic [AW-1:0]               slot_data [2];
  logic [ANCHOR_CNT_WIDTH-1:0] slot_tag  [2];

  logic          beat_xfer;
  logic          anc_xfer;
  logic          last_beat;
  logic [CW-1:0] beat_cnt_next;
  logic          frag_set;

  // Accept depends only on registered state (and reset), never on anc_ready.
  assign beat_accept = rst_n && (state == COLLECT) && !full[wr_slot];
  assign anc_valid   = full[rd_slot];
  assign anc_feature = anc_valid ? slot_data[rd_slot] : '0;
  assign anc_index   = anc_valid ? slot_tag[rd_slot]  : '0;

  assign beat_xfer = beat_accept && beat_avail;
  assign anc_xfer  = anc_valid && anc_ready;
  assign last_beat = beat_xfer && (beat_cnt == LAST_BEAT);

  always_comb begin
    beat_cnt_next = beat_cnt;
    if (last_beat)
      beat_cnt_next = '0;
    else if (beat_xfer)
      beat_cnt_next = beat_cnt + 1'b1;
  end

  // A pass ending with beats left over means the anchor in flight is incomplete.
  assign frag_set = (state == COLLECT) && search_done && (beat_cnt_next != '0);

  // Slot payload storage: not reset, visibility is gated by the full flags.
  always_ff @(posedge clk) begin
    if (beat_xfer)
      slot_data[wr_slot][beat_cnt*DATA_BUS_WIDTH +: DATA_BUS_WIDTH] <= beat_in;
    if (last_beat)
      slot_tag[wr_slot] <= anc_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= COLLECT;
      full       <= 2'b00;
      wr_slot    <= 1'b0;
      rd_slot    <= 1'b0;
      beat_cnt   <= '0;
      anc_cnt    <= '0;
      pass_done  <= 1'b0;
      pass_count <= '0;
      frag_err   <= 1'b0;
    end else begin
      pass_done <= 1'b0;
      beat_cnt  <= beat_cnt_next;

      // Fill and drain always target different slots, so both can land together.
      if (anc_xfer) begin
        full[rd_slot] <= 1'b0;
        rd_slot       <= ~rd_slot;
      end
      if (last_beat) begin
        full[wr_slot] <= 1'b1;
        wr_slot       <= ~wr_slot;
        anc_cnt       <= anc_cnt + 1'b1;
      end

      if (frag_set)
        frag_err <= 1'b1;
      else if (err_clr)
        frag_err <= 1'b0;

      case (state)
        COLLECT: begin
          if (search_done) begin
            state <= FLUSH;
            if (frag_set)
              beat_cnt <= '0;
          end
        end
        FLUSH: begin
          if (full == 2'b00) begin
            pass_done  <= 1'b1;
            pass_count <= anc_cnt;
            anc_cnt    <= '0;
            state      <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_anchor_feature_collector.sv
// Randomised and directed bench for anchor_feature_collector against a
// queue-based model of the anchor stream.
module tb_anchor_feature_collector;

  localparam int DW  = 64;
  localparam int FL  = 9;
  localparam int ACW = 16;
  localparam int AW  = FL * DW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [DW-1:0]  beat_in;
  logic           beat_avail;
  logic           beat_accept;
  logic           search_done;
  logic [AW-1:0]  anc_feature;
  logic [ACW-1:0] anc_index;
  logic           anc_valid;
  logic           anc_ready;
  logic           pass_done;
  logic [ACW-1:0] pass_count;
  logic           frag_err;
  logic           err_clr;

  always #5 clk = ~clk;

  anchor_feature_collector #(
    .DATA_BUS_WIDTH(DW),
    .FEATURE_LENTH(FL),
    .ANCHOR_CNT_WIDTH(ACW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .beat_in(beat_in),
    .beat_avail(beat_avail),
    .beat_accept(beat_accept),
    .search_done(search_done),
    .anc_feature(anc_feature),
    .anc_index(anc_index),
    .anc_valid(anc_valid),
    .anc_ready(anc_ready),
    .pass_done(pass_done),
    .pass_count(pass_count),
    .frag_err(frag_err),
    .err_clr(err_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: completed anchors waiting for the renderer, plus the anchor being built.
  logic [AW-1:0]  q_feat [$];
  logic [ACW-1:0] q_idx  [$];
  logic [AW-1:0]  part;
  int             part_cnt = 0;
  logic [ACW-1:0] m_cnt = '0;
  bit             m_flush = 0;
  bit             m_frag = 0;
  bit             m_pd = 0;
  logic [ACW-1:0] m_pc = '0;
  bit             m_xfer = 0;
  bit             armed = 0;

  // Observed DUT traffic for the directed literal checks.
  logic [AW-1:0]  rx_feat [$];
  logic [ACW-1:0] rx_idx  [$];
  int             pd_cnt = 0;
  logic [ACW-1:0] last_pc = '0;

  always @(negedge clk) begin
    bit             e_acc, e_vld, drain, beat, fset;
    logic [AW-1:0]  e_feat;
    logic [ACW-1:0] e_idx;
    int             qs;
    e_acc  = rst_n && !m_flush && (q_feat.size() < 2);
    e_vld  = (q_feat.size() > 0);
    e_feat = e_vld ? q_feat[0] : '0;
    e_idx  = e_vld ? q_idx[0]  : '0;
    if (armed) begin
      check("beat_accept", AW'(beat_accept), AW'(e_acc));
      check("anc_valid",   AW'(anc_valid),   AW'(e_vld));
      check("anc_feature", anc_feature,      e_feat);
      check("anc_index",   AW'(anc_index),   AW'(e_idx));
      check("pass_done",   AW'(pass_done),   AW'(m_pd));
      check("pass_count",  AW'(pass_count),  AW'(m_pc));
      check("frag_err",    AW'(frag_err),    AW'(m_frag));
      if (rst_n && anc_valid && anc_ready) begin
        rx_feat.push_back(anc_feature);
        rx_idx.push_back(anc_index);
      end
      if (pass_done) begin
        pd_cnt++;
        last_pc = pass_count;
      end
    end
    if (!rst_n) begin
      q_feat.delete();
      q_idx.delete();
      part_cnt = 0;
      m_cnt    = '0;
      m_flush  = 0;
      m_frag   = 0;
      m_pd     = 0;
      m_pc     = '0;
      m_xfer   = 0;
      armed    = 1;
    end else begin
      qs     = q_feat.size();
      drain  = e_vld && anc_ready;
      beat   = e_acc && beat_avail;
      m_xfer = beat;
      if (drain) begin
        void'(q_feat.pop_front());
        void'(q_idx.pop_front());
      end
      if (beat) begin
        part[part_cnt*DW +: DW] = beat_in;
        part_cnt++;
        if (part_cnt == FL) begin
          q_feat.push_back(part);
          q_idx.push_back(m_cnt);
          m_cnt    = m_cnt + 1'b1;
          part_cnt = 0;
        end
      end
      fset = !m_flush && search_done && (part_cnt != 0);
      if (fset) m_frag = 1;
      else if (err_clr) m_frag = 0;
      m_pd = 0;
      if (!m_flush) begin
        if (search_done) begin
          m_flush = 1;
          part_cnt = 0;
        end
      end else if (qs == 0) begin
        m_pd    = 1;
        m_pc    = m_cnt;
        m_cnt   = '0;
        m_flush = 0;
      end
    end
  end

  logic [DW-1:0] nxt;
  int            rb;
  int            pd0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n);
    int got = 0;
    int guard = 0;
    while (got < n && guard < 2000) begin
      beat_avail = 1'b1;
      beat_in    = nxt;
      step();
      guard++;
      if (m_xfer) begin
        got++;
        nxt = nxt + 1;
      end
    end
    beat_avail = 1'b0;
    if (got < n) check("send_timeout", AW'(got), AW'(n));
  endtask

  task automatic pulse_done();
    search_done = 1'b1;
    step();
    search_done = 1'b0;
  endtask

  task automatic wait_pd();
    int start = pd_cnt;
    int g = 0;
    while (pd_cnt == start && g < 300) begin
      step();
      g++;
    end
    if (pd_cnt == start) check("pass_done_timeout", AW'(pd_cnt - start), AW'(1));
  endtask

  initial begin
    rst_n = 1'b0; beat_in = '0; beat_avail = 1'b0; search_done = 1'b0;
    anc_ready = 1'b0; err_clr = 1'b0; nxt = '0;
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    check("accept_after_reset", AW'(beat_accept), AW'(1));

    // Two anchors streamed with the renderer always ready.
    anc_ready = 1'b1; nxt = 0; rb = rx_feat.size();
    send(18);
    pulse_done();
    wait_pd();
    check("t1_rx_count", AW'(rx_feat.size() - rb), AW'(2));
    check("t1_a0_beat0", AW'(rx_feat[rb][63:0]), AW'(0));
    check("t1_a0_beat8", AW'(rx_feat[rb][575:512]), AW'(8));
    check("t1_a0_index", AW'(rx_idx[rb]), AW'(0));
    check("t1_a1_beat0", AW'(rx_feat[rb+1][63:0]), AW'(9));
    check("t1_a1_index", AW'(rx_idx[rb+1]), AW'(1));
    check("t1_pass_count", AW'(last_pc), AW'(2));
    check("t1_frag_err", AW'(frag_err), AW'(0));

    // Back-pressure: both slots fill, stream stalls, then drains in order.
    anc_ready = 1'b0; nxt = 0; rb = rx_feat.size();
    send(18);
    repeat (3) step();
    check("t2_stalled", AW'(beat_accept), AW'(0));
    check("t2_held_valid", AW'(anc_valid), AW'(1));
    check("t2_held_index", AW'(anc_index), AW'(0));
    check("t2_held_beat0", AW'(anc_feature[63:0]), AW'(0));
    anc_ready = 1'b1;
    send(9);
    pulse_done();
    wait_pd();
    check("t2_rx_count", AW'(rx_feat.size() - rb), AW'(3));
    check("t2_a2_index", AW'(rx_idx[rb+2]), AW'(2));
    check("t2_a2_beat0", AW'(rx_feat[rb+2][63:0]), AW'(18));
    check("t2_pass_count", AW'(last_pc), AW'(3));

    // Fragmented pass: 13 beats leave a partial anchor behind.
    nxt = 100; rb = rx_feat.size();
    send(13);
    pulse_done();
    wait_pd();
    check("t3_pass_count", AW'(last_pc), AW'(1));
    check("t3_frag_err", AW'(frag_err), AW'(1));
    check("t3_rx_count", AW'(rx_feat.size() - rb), AW'(1));
    rb = rx_feat.size();
    send(9);
    repeat (3) step();
    check("t3_new_pass_index", AW'(rx_idx[rb]), AW'(0));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t3_err_clr", AW'(frag_err), AW'(0));
    pulse_done();
    wait_pd();

    // search_done coincides with the ninth beat: the anchor still completes.
    send(8);
    beat_avail = 1'b1; beat_in = nxt; search_done = 1'b1;
    step();
    beat_avail = 1'b0; search_done = 1'b0;
    wait_pd();
    check("t4_pass_count", AW'(last_pc), AW'(1));
    check("t4_frag_err", AW'(frag_err), AW'(0));

    // Reset with one slot full and five beats in flight.
    anc_ready = 1'b0;
    send(14);
    step();
    rst_n = 1'b0;
    #1;
    check("t5_accept_in_reset", AW'(beat_accept), AW'(0));
    step();
    check("t5_valid", AW'(anc_valid), AW'(0));
    check("t5_pass_count", AW'(pass_count), AW'(0));
    check("t5_feature", anc_feature, AW'(0));
    check("t5_index", AW'(anc_index), AW'(0));
    rst_n = 1'b1; anc_ready = 1'b1; rb = rx_feat.size();
    send(9);
    repeat (3) step();
    check("t5_rx_count", AW'(rx_feat.size() - rb), AW'(1));
    check("t5_fresh_index", AW'(rx_idx[rb]), AW'(0));
    pulse_done();
    wait_pd();

    // Renderer stalled through search_done: the pass cannot close until drained.
    anc_ready = 1'b0;
    send(18);
    pulse_done();
    pd0 = pd_cnt;
    repeat (10) step();
    check("t6_no_pass_done", AW'(pd_cnt - pd0), AW'(0));
    check("t6_accept_blocked", AW'(beat_accept), AW'(0));
    anc_ready = 1'b1;
    wait_pd();
    check("t6_pass_count", AW'(last_pc), AW'(2));

    // Random traffic, pass boundaries, error clears and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      beat_avail  = ($urandom_range(0, 3) != 0);
      beat_in     = {$urandom, $urandom};
      anc_ready   = ($urandom_range(0, 2) != 0);
      search_done = ($urandom_range(0, 60) == 0);
      err_clr     = ($urandom_range(0, 40) == 0);
      rst_n       = ($urandom_range(0, 800) != 0);
      step();
    end
    beat_avail = 1'b0; search_done = 1'b0; err_clr = 1'b0; rst_n = 1'b1;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/anchor_feature_collector.md
# anchor_feature_collector

Downstream consumer of the octree searcher's beat stream. It accepts DATA_BUS_WIDTH-wide feature beats from the octree `feature_out` handshake and packs every FEATURE_LENTH consecutive beats into one full anchor feature. Up to two complete anchors are buffered in ping-pong slots and presented on a valid/ready port to the rendering pipeline. It also closes each search pass on `search_done`: partial anchors are flagged, and a completion pulse reports the anchor count.

## Interface
- DATA_BUS_WIDTH, 64, beat width; matches octree `feature_out`.
- FEATURE_LENTH, 9, beats per anchor feature (36×16 bit = 9×64 bit).
- ANCHOR_CNT_WIDTH, 16, width of the anchor index/count.
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- beat_in  in  DATA_BUS_WIDTH  feature beat; connects to octree `feature_out`.
- beat_avail  in  1  beat present; connects to octree `out_ready`.
- beat_accept  out  DATA_BUS_WIDTH?1  accept strobe; drives octree `out_valid`. A beat transfers on a clk edge where beat_avail && beat_accept.
- search_done  in  1  octree pass finished (one-cycle pulse).
- anc_feature  out  FEATURE_LENTH*DATA_BUS_WIDTH  packed anchor; beat k occupies bits [k*DATA_BUS_WIDTH +: DATA_BUS_WIDTH].
- anc_index  out  ANCHOR_CNT_WIDTH  index of the presented anchor within the current pass.
- anc_valid  out  1  anc_feature/anc_index valid.
- anc_ready  in  1  downstream accepts; anchor transfers when anc_valid && anc_ready.
- pass_done  out  1  one-cycle pulse: pass finished, all anchors drained.
- pass_count  out  ANCHOR_CNT_WIDTH  anchors completed in the pass; valid with pass_done, held until the next pulse.
- frag_err  out  1  sticky: a pass ended mid-anchor.
- err_clr  in  1  clears frag_err.

Note: beat_accept width is 1.

## Operation
- Storage:
  - Two slots, each FEATURE_LENTH×DATA_BUS_WIDTH wide, with full[1:0] flags and a per-slot index tag.
  - Pointers: wr_slot, rd_slot.
  - beat_cnt runs 0..FEATURE_LENTH-1; anc_cnt is ANCHOR_CNT_WIDTH wide.
- States:
  - COLLECT (reset state).
  - FLUSH.
- beat_accept = (state==COLLECT) && !full[wr_slot]. It is derived from registers only; there is no combinational path from anc_ready.
- Beat transfer:
  - Write beat_in into slot[wr_slot] at position beat_cnt, then beat_cnt++.
  - On the beat with beat_cnt==FEATURE_LENTH-1: set full[wr_slot], tag it with anc_cnt, anc_cnt++, toggle wr_slot, and clear beat_cnt to 0.
- Output side:
  - anc_valid = full[rd_slot]; anc_feature and anc_index come from slot[rd_slot].
  - On an anchor transfer: clear full[rd_slot] and toggle rd_slot.
  - anc_feature and anc_index hold stable while anc_valid && !anc_ready.
- Fill and drain in the same cycle operate on different slots; both take effect.
- A slot freed in cycle T is fillable from T+1.
- search_done in COLLECT:
  - Any beat transferring in the same cycle is processed first.
  - If the resulting beat_cnt != 0: set frag_err, discard the partial anchor (beat_cnt←0), and do not increment anc_cnt.
  - Then go to FLUSH.
- FLUSH:
  - beat_accept=0.
  - When full==2'b00: pulse pass_done, load pass_count←anc_cnt, clear anc_cnt←0, return to COLLECT.
- search_done while in FLUSH is ignored.
- err_clr clears frag_err. If err_clr and a new fragment event occur in the same cycle, the set wins.
- anc_cnt wraps modulo 2^ANCHOR_CNT_WIDTH without error.

## Timing
- Reset (rst_n low at a clk edge):
  - state=COLLECT; full=0; wr_slot=rd_slot=0; beat_cnt=0; anc_cnt=0.
  - Outputs: anc_valid=0, pass_done=0, pass_count=0, frag_err=0, anc_index=0, anc_feature=0.
  - beat_accept is forced 0 while rst_n is low.
  - Reset mid-anchor or mid-FLUSH drops all buffered data; no pass_done is generated.
- First cycle after reset release: beat_accept=1.
- Latency: the last beat of an anchor accepted at edge T gives anc_valid=1 in cycle T+1.
- Throughput: one beat per cycle. The stream never stalls if anc_ready is high at least once every FEATURE_LENTH cycles.
- Back-pressure: both slots full → beat_accept=0 from the cycle after the second fill. It returns to 1 the cycle after a drain.
- pass_done asserts at the earliest one cycle after the last anchor transfer, and at least one cycle after search_done.

## Test plan
- Stream 18 beats (values 0..17), anc_ready=1, then search_done:
  - Anchor 0 has beats 0..8 with anc_feature[63:0]=0, anc_index=0.
  - Anchor 1 has beats 9..17, anc_index=1.
  - pass_done pulses with pass_count=2; frag_err=0.
- anc_ready=0, stream 27 beats:
  - beat_accept drops after beat 17; slots hold anchors 0 and 1, stable.
  - Raise anc_ready: anchors drain in order and beats 18..26 are accepted; anchor 2 has anc_index=2.
- Stream 13 beats, then search_done:
  - One anchor out; frag_err=1; pass_count=1.
  - Next pass starts at anc_index=0.
  - err_clr clears frag_err.
- search_done in the same cycle as the 9th beat:
  - The anchor completes; frag_err=0; pass_count=1.
- Pull rst_n low with 5 beats buffered and one slot full:
  - All outputs at reset values the next cycle; beat_accept=0 during reset.
  - A fresh 9-beat stream yields anc_index=0.
- Hold anc_ready=0 through search_done:
  - State stays FLUSH with beat_accept=0 and no pass_done.
  - pass_done asserts one cycle after the final anchor drains.
